// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: fault codes, the NOP filler
// and the buffered instruction entry carried from memory to decode.
package if_pkg;

    localparam logic [31:0] IF_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_FAULT_NONE     = 2'b00,
        IF_FAULT_ACCESS   = 2'b01,
        IF_FAULT_MISALIGN = 2'b10
    } if_fault_e;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        if_fault_e   fault;
    } if_entry_t;

    localparam if_entry_t IF_RESET_ENTRY = '{
        instruction: IF_NOP,
        pc:          32'h0000_0000,
        fault:       IF_FAULT_NONE
    };

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; the head is read straight from the
// storage flops, and a flush may carry a push that becomes the only entry.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  if_entry_t                i_pushData,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output if_entry_t                o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_rdPtr;
    logic [PW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= IF_RESET_ENTRY;
            end
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            if (i_push) begin
                r_mem[0] <= i_pushData;
                r_wrPtr  <= PW'(1);
                r_count  <= CW'(1);
            end else begin
                r_wrPtr  <= '0;
                r_count  <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word fetches and buffers the
// returned words for decode; redirects flush the buffer and drop stale responses.
module instruction_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [1:0]  if_fault
);
    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic            r_active;
    logic            r_halted;
    logic [31:0]     r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_fifoCount;
    logic [CW-1:0]   w_tagCount;
    logic [CW:0]     w_credit;
    logic            w_reqFire;
    logic            w_rspDrop;
    logic            w_rspKeep;
    logic            w_misalign;
    logic            w_fifoPush;
    logic            w_fifoPop;
    logic            w_unusedTag;
    if_entry_t       w_pushEntry;
    if_entry_t       w_tagEntry;
    if_entry_t       w_tagHead;
    if_entry_t       w_head;

    assign w_credit       = {1'b0, r_inflight} + {1'b0, w_fifoCount};
    assign imem_req_valid = r_active && !r_halted && !redirect_valid && (w_credit < CREDIT_LIMIT);
    assign imem_req_addr  = r_pc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;

    // A response in a redirect cycle is as stale as any already marked for discard.
    assign w_rspDrop  = redirect_valid || (r_discard != '0);
    assign w_rspKeep  = imem_rsp_valid && !w_rspDrop;
    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_fifoPush = w_misalign || w_rspKeep;

    assign if_valid       = (w_fifoCount != '0);
    assign w_fifoPop      = if_valid && id_ready;
    assign if_instruction = w_head.instruction;
    assign if_pc          = w_head.pc;
    assign if_fault       = w_head.fault;

    always_comb begin
        w_tagEntry    = IF_RESET_ENTRY;
        w_tagEntry.pc = r_pc;
    end

    always_comb begin
        w_pushEntry.instruction = imem_rsp_data;
        w_pushEntry.pc          = w_tagHead.pc;
        w_pushEntry.fault       = imem_rsp_err ? IF_FAULT_ACCESS : IF_FAULT_NONE;
        if (w_misalign) begin
            w_pushEntry.instruction = IF_NOP;
            w_pushEntry.pc          = redirect_pc;
            w_pushEntry.fault       = IF_FAULT_MISALIGN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_halted   <= 1'b0;
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= r_inflight + CW'(w_reqFire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_discard <= r_inflight - CW'(imem_rsp_valid);
                r_halted  <= w_misalign;
                if (!w_misalign) begin
                    r_pc <= redirect_pc;
                end
            end else begin
                if (imem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_reqFire) begin
                    r_pc <= r_pc + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_instrFifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_fifoPush),
        .i_pushData (w_pushEntry),
        .i_pop      (w_fifoPop),
        .i_flush    (redirect_valid),
        .o_count    (w_fifoCount),
        .o_head     (w_head)
    );

    // Request PCs of live fetches; only the pc field of each entry matters.
    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_tagQueue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_reqFire),
        .i_pushData (w_tagEntry),
        .i_pop      (w_rspKeep),
        .i_flush    (redirect_valid),
        .o_count    (w_tagCount),
        .o_head     (w_tagHead)
    );

    assign w_unusedTag = ^{w_tagHead.instruction, w_tagHead.fault, w_tagCount};

endmodule
